// File: rtl/input_arbiter_pkg.sv
// Shared types and helpers for the controller input arbiter.
// Source codes, the direction vector, the FSM state and the opposite-direction sanitizer.
package input_arb_pkg;

  typedef enum logic [1:0] {
    SRC_NES  = 2'b00,
    SRC_IR   = 2'b01,
    SRC_PS2  = 2'b10,
    SRC_NONE = 2'b11
  } src_e;

  localparam logic [1:0] MODE_AUTO = 2'b11;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  // Opposing presses cancel so game logic never sees an impossible direction.
  function automatic dir_t sanitize(input dir_t d);
    dir_t s;
    s = d;
    if (d.up && d.down) begin
      s.up   = 1'b0;
      s.down = 1'b0;
    end
    if (d.left && d.right) begin
      s.left  = 1'b0;
      s.right = 1'b0;
    end
    return s;
  endfunction

  function automatic src_e next_src(input src_e s);
    case (s)
      SRC_NES: return SRC_IR;
      SRC_IR:  return SRC_PS2;
      default: return SRC_NES;
    endcase
  endfunction

endpackage

// File: rtl/input_arbiter_if.sv
// Bundle between the three controller front-ends plus mode select and the arbiter.
// master drives the controller side, slave is the arbiter.
interface input_arbiter_if;
  import input_arb_pkg::*;

  logic [1:0] Choice;
  dir_t       NDir;
  logic       NReadable;
  dir_t       IDir;
  logic       IReadable;
  dir_t       PDir;
  logic       PReadable;
  logic       Up;
  logic       Down;
  logic       Left;
  logic       Right;
  logic       Valid;
  logic [1:0] Source;

  modport master (
    output Choice, NDir, NReadable, IDir, IReadable, PDir, PReadable,
    input  Up, Down, Left, Right, Valid, Source
  );

  modport slave (
    input  Choice, NDir, NReadable, IDir, IReadable, PDir, PReadable,
    output Up, Down, Left, Right, Valid, Source
  );
endinterface

// File: rtl/input_arbiter_debounce.sv
// Stability filter: load pulses only once the same vector has been sampled for DEBOUNCE_CYCLES clocks.
// Instantiated by input_arbiter only when INPUT_ARB_DEBOUNCE_EN is defined.
module input_debounce
  import input_arb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250_000
) (
  input  logic clk,
  input  logic srst,
  input  dir_t din,
  input  logic sample,
  input  logic clear,
  output dir_t dout,
  output logic load
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  dir_t          cand_reg;
  logic          have_reg;
  logic [CW-1:0] cnt_reg;
  logic          same;

  assign same = have_reg && (din == cand_reg);
  assign load = sample && same && (cnt_reg >= CW'(DEBOUNCE_CYCLES - 1));
  assign dout = cand_reg;

  // The count runs in clocks from the first sample of a vector; a differing sample restarts it.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      cand_reg <= '0;
      have_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (sample && !same) begin
      cand_reg <= din;
      have_reg <= 1'b1;
      cnt_reg  <= CW'(1);
    end else if (have_reg && (cnt_reg != {CW{1'b1}})) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/input_arbiter.sv
// Direction-path arbiter between NES/SNES, IR and PS2 front-ends and game logic.
// Optional stability filter on the forwarded vector: define INPUT_ARB_DEBOUNCE_EN.
module input_arbiter
  import input_arb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = 25_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 250_000
) (
  input logic          Clock,
  input logic          Reset,
  input_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

  state_e         state_reg, state_next;
  src_e           lock_reg, lock_next;
  src_e           rr_reg, rr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  dir_t           dir_reg, dir_next;
  logic           valid_reg, valid_next;
  logic [1:0]     source_reg, source_next;
  logic [1:0]     choice_prev_reg;

  dir_t       dir_arr [4];
  logic [3:0] rd;
  logic [3:0] claim;
  logic       manual, choice_changed, win_found, sample, release_lock, load_en;
  src_e       win_src, act_src, cand;
  dir_t       act_dir, load_dir;

  assign dir_arr[0] = bus.NDir;
  assign dir_arr[1] = bus.IDir;
  assign dir_arr[2] = bus.PDir;
  assign dir_arr[3] = '0;
  assign rd         = {1'b0, bus.PReadable, bus.IReadable, bus.NReadable};
  assign claim[3]   = 1'b0;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_claim
      assign claim[gi] = rd[gi] && (dir_arr[gi] != '0);
    end
  endgenerate

  assign manual         = (bus.Choice != MODE_AUTO);
  assign choice_changed = (bus.Choice != choice_prev_reg);

  // Round-robin pick: first claimant at or after the pointer.
  always_comb begin
    win_found = 1'b0;
    win_src   = SRC_NES;
    cand      = rr_reg;
    for (int k = 0; k < 3; k++) begin
      if (!win_found && claim[cand]) begin
        win_found = 1'b1;
        win_src   = cand;
      end
      cand = next_src(cand);
    end
  end

  assign act_src = manual ? src_e'(bus.Choice)
                 : ((state_reg == ST_LOCKED) ? lock_reg : win_src);
  assign act_dir = sanitize(dir_arr[act_src]);
  assign sample  = !choice_changed && rd[act_src]
                 && (manual || (state_reg == ST_LOCKED) || win_found);
  assign release_lock = !choice_changed && !manual && (state_reg == ST_LOCKED)
                      && !rd[lock_reg] && (cnt_reg == CNT_W'(HOLD_CYCLES - 1));

`ifdef INPUT_ARB_DEBOUNCE_EN
  logic flt_clear;
  assign flt_clear = choice_changed || release_lock
                   || (!manual && (state_reg == ST_IDLE) && !win_found);

  input_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (Clock),
    .srst   (Reset),
    .din    (act_dir),
    .sample (sample),
    .clear  (flt_clear),
    .dout   (load_dir),
    .load   (load_en)
  );
`else
  assign load_dir = act_dir;
  assign load_en  = sample;
`endif

  always_comb begin
    state_next  = state_reg;
    lock_next   = lock_reg;
    rr_next     = rr_reg;
    cnt_next    = cnt_reg;
    dir_next    = dir_reg;
    valid_next  = valid_reg;
    source_next = source_reg;
    if (choice_changed) begin
      state_next  = ST_IDLE;
      cnt_next    = '0;
      dir_next    = '0;
      valid_next  = 1'b0;
      source_next = SRC_NONE;
    end else if (manual) begin
      state_next  = ST_IDLE;
      source_next = bus.Choice;
      if (load_en) begin
        dir_next   = load_dir;
        valid_next = 1'b1;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cnt_next    = '0;
          dir_next    = '0;
          valid_next  = 1'b0;
          source_next = SRC_NONE;
          if (win_found) begin
            state_next  = ST_LOCKED;
            lock_next   = win_src;
            source_next = win_src;
            if (load_en) begin
              dir_next   = load_dir;
              valid_next = 1'b1;
            end
          end
        end
        default: begin
          if (rd[lock_reg]) begin
            cnt_next = '0;
            if (load_en) begin
              dir_next   = load_dir;
              valid_next = 1'b1;
            end
          end else if (release_lock) begin
            state_next  = ST_IDLE;
            cnt_next    = '0;
            dir_next    = '0;
            valid_next  = 1'b0;
            source_next = SRC_NONE;
            rr_next     = next_src(lock_reg);
          end else if (cnt_reg != {CNT_W{1'b1}}) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // choice_prev tracks Choice during reset so a steady mode is not seen as a change.
  always_ff @(posedge Clock) begin
    choice_prev_reg <= bus.Choice;
    if (Reset) begin
      state_reg  <= ST_IDLE;
      lock_reg   <= SRC_NES;
      rr_reg     <= SRC_NES;
      cnt_reg    <= '0;
      dir_reg    <= '0;
      valid_reg  <= 1'b0;
      source_reg <= SRC_NONE;
    end else begin
      state_reg  <= state_next;
      lock_reg   <= lock_next;
      rr_reg     <= rr_next;
      cnt_reg    <= cnt_next;
      dir_reg    <= dir_next;
      valid_reg  <= valid_next;
      source_reg <= source_next;
    end
  end

  assign bus.Up     = dir_reg.up;
  assign bus.Down   = dir_reg.down;
  assign bus.Left   = dir_reg.left;
  assign bus.Right  = dir_reg.right;
  assign bus.Valid  = valid_reg;
  assign bus.Source = source_reg;

endmodule

// File: tb/tb_input_arbiter.sv
// Directed bench for input_arbiter with HOLD_CYCLES=8, DEBOUNCE_CYCLES=4.
// Define INPUT_ARB_DEBOUNCE_EN for both RTL and bench to run the filter scenario.
module tb_input_arbiter;
  import input_arb_pkg::*;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  input_arbiter_if bus ();

  input_arbiter #(
    .HOLD_CYCLES     (8),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.NReadable = 1'b0;
    bus.IReadable = 1'b0;
    bus.PReadable = 1'b0;
    bus.NDir = 4'b0000;
    bus.IDir = 4'b0000;
    bus.PDir = 4'b0000;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.Choice = 2'b01;
    Reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.Up, bus.Down, bus.Left, bus.Right} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_dir: got %b want 0000", {bus.Up, bus.Down, bus.Left, bus.Right});
    end
    checks++;
    if (bus.Valid !== 1'b0 || bus.Source !== 2'b11) begin
      failures++;
      $display("FAIL reset_valid_src: got valid=%b src=%b want valid=0 src=11", bus.Valid, bus.Source);
    end
    $display("test_reset: dir=%b valid=%b src=%b", {bus.Up, bus.Down, bus.Left, bus.Right}, bus.Valid, bus.Source);
    Reset = 1'b0;
  endtask

  task automatic test_manual_ir();
    bus.NDir = 4'b0001;
    bus.NReadable = 1'b1;
    tick();
    bus.NReadable = 1'b0;
    checks++;
    if ({bus.Right, bus.Valid, bus.Source} !== 4'b0_0_01) begin
      failures++;
      $display("FAIL manual_ignore_nes: got right=%b valid=%b src=%b want 0 0 01", bus.Right, bus.Valid, bus.Source);
    end
    bus.IDir = 4'b1000;
    bus.IReadable = 1'b1;
    tick();
    bus.IReadable = 1'b0;
    checks++;
    if ({bus.Up, bus.Down, bus.Left, bus.Right, bus.Valid, bus.Source} !== 7'b1000_1_01) begin
      failures++;
      $display("FAIL manual_ir_load: got dir=%b valid=%b src=%b want 1000 1 01",
               {bus.Up, bus.Down, bus.Left, bus.Right}, bus.Valid, bus.Source);
    end
    bus.IDir = 4'b0100;
    tick();
    checks++;
    if (bus.Up !== 1'b1 || bus.Down !== 1'b0) begin
      failures++;
      $display("FAIL manual_hold: got up=%b down=%b want 1 0", bus.Up, bus.Down);
    end
    $display("test_manual_ir: dir=%b valid=%b src=%b", {bus.Up, bus.Down, bus.Left, bus.Right}, bus.Valid, bus.Source);
  endtask

  task automatic test_auto_tie();
    idle_inputs();
    bus.Choice = 2'b11;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (bus.Source !== 2'b11 || bus.Valid !== 1'b0) begin
      failures++;
      $display("FAIL auto_idle: got src=%b valid=%b want 11 0", bus.Source, bus.Valid);
    end
    bus.NDir = 4'b0010;
    bus.NReadable = 1'b1;
    bus.PDir = 4'b0001;
    bus.PReadable = 1'b1;
    tick();
    bus.NReadable = 1'b0;
    bus.PReadable = 1'b0;
    checks++;
    if ({bus.Up, bus.Down, bus.Left, bus.Right, bus.Valid, bus.Source} !== 7'b0010_1_00) begin
      failures++;
      $display("FAIL auto_tie_nes: got dir=%b valid=%b src=%b want 0010 1 00",
               {bus.Up, bus.Down, bus.Left, bus.Right}, bus.Valid, bus.Source);
    end
    $display("test_auto_tie: dir=%b valid=%b src=%b", {bus.Up, bus.Down, bus.Left, bus.Right}, bus.Valid, bus.Source);
  endtask

  task automatic test_hold_release();
    repeat (7) tick();
    checks++;
    if (bus.Source !== 2'b00 || bus.Left !== 1'b1) begin
      failures++;
      $display("FAIL hold_7_idle: got src=%b left=%b want 00 1", bus.Source, bus.Left);
    end
    tick();
    checks++;
    if ({bus.Up, bus.Down, bus.Left, bus.Right, bus.Valid, bus.Source} !== 7'b0000_0_11) begin
      failures++;
      $display("FAIL hold_release: got dir=%b valid=%b src=%b want 0000 0 11",
               {bus.Up, bus.Down, bus.Left, bus.Right}, bus.Valid, bus.Source);
    end
    bus.NDir = 4'b0010;
    bus.NReadable = 1'b1;
    bus.PDir = 4'b0001;
    bus.PReadable = 1'b1;
    tick();
    bus.NReadable = 1'b0;
    bus.PReadable = 1'b0;
    checks++;
    if ({bus.Left, bus.Right, bus.Source} !== 4'b01_10) begin
      failures++;
      $display("FAIL rr_advance: got left=%b right=%b src=%b want 0 1 10", bus.Left, bus.Right, bus.Source);
    end
    $display("test_hold_release: dir=%b valid=%b src=%b", {bus.Up, bus.Down, bus.Left, bus.Right}, bus.Valid, bus.Source);
  endtask

  task automatic test_sanitize();
    bus.Choice = 2'b10;
    tick();
    checks++;
    if (bus.Right !== 1'b0 || bus.Valid !== 1'b0 || bus.Source !== 2'b11) begin
      failures++;
      $display("FAIL change_clear: got right=%b valid=%b src=%b want 0 0 11", bus.Right, bus.Valid, bus.Source);
    end
    bus.PDir = 4'b1100;
    bus.PReadable = 1'b1;
    tick();
    checks++;
    if ({bus.Up, bus.Down, bus.Left, bus.Right, bus.Valid, bus.Source} !== 7'b0000_1_10) begin
      failures++;
      $display("FAIL sanitize_ud: got dir=%b valid=%b src=%b want 0000 1 10",
               {bus.Up, bus.Down, bus.Left, bus.Right}, bus.Valid, bus.Source);
    end
    bus.PDir = 4'b1110;
    tick();
    checks++;
    if ({bus.Up, bus.Down, bus.Left, bus.Right} !== 4'b0010) begin
      failures++;
      $display("FAIL sanitize_udl: got %b want 0010", {bus.Up, bus.Down, bus.Left, bus.Right});
    end
    bus.PDir = 4'b1011;
    tick();
    bus.PReadable = 1'b0;
    checks++;
    if ({bus.Up, bus.Down, bus.Left, bus.Right} !== 4'b1000) begin
      failures++;
      $display("FAIL sanitize_ulr: got %b want 1000", {bus.Up, bus.Down, bus.Left, bus.Right});
    end
    $display("test_sanitize: dir=%b valid=%b src=%b", {bus.Up, bus.Down, bus.Left, bus.Right}, bus.Valid, bus.Source);
  endtask

  task automatic test_choice_change();
    bus.Choice = 2'b11;
    tick();
    bus.IDir = 4'b1000;
    bus.IReadable = 1'b1;
    tick();
    bus.IReadable = 1'b0;
    checks++;
    if (bus.Source !== 2'b01 || bus.Up !== 1'b1) begin
      failures++;
      $display("FAIL lock_ir: got src=%b up=%b want 01 1", bus.Source, bus.Up);
    end
    repeat (5) tick();
    bus.IReadable = 1'b1;
    tick();
    bus.IReadable = 1'b0;
    repeat (7) tick();
    checks++;
    if (bus.Source !== 2'b01) begin
      failures++;
      $display("FAIL idle_refresh: got src=%b want 01", bus.Source);
    end
    bus.Choice = 2'b00;
    tick();
    checks++;
    if ({bus.Up, bus.Down, bus.Left, bus.Right, bus.Valid, bus.Source} !== 7'b0000_0_11) begin
      failures++;
      $display("FAIL midlock_change: got dir=%b valid=%b src=%b want 0000 0 11",
               {bus.Up, bus.Down, bus.Left, bus.Right}, bus.Valid, bus.Source);
    end
    bus.NDir = 4'b0100;
    bus.NReadable = 1'b1;
    tick();
    bus.NReadable = 1'b0;
    checks++;
    if ({bus.Up, bus.Down, bus.Left, bus.Right, bus.Valid, bus.Source} !== 7'b0100_1_00) begin
      failures++;
      $display("FAIL nes_after_change: got dir=%b valid=%b src=%b want 0100 1 00",
               {bus.Up, bus.Down, bus.Left, bus.Right}, bus.Valid, bus.Source);
    end
    $display("test_choice_change: dir=%b valid=%b src=%b", {bus.Up, bus.Down, bus.Left, bus.Right}, bus.Valid, bus.Source);
  endtask

`ifdef INPUT_ARB_DEBOUNCE_EN
  task automatic test_debounce();
    bus.IReadable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.IDir = (i % 2 == 0) ? 4'b1000 : 4'b0100;
      tick();
    end
    checks++;
    if ({bus.Up, bus.Down, bus.Valid} !== 3'b000) begin
      failures++;
      $display("FAIL debounce_toggle: got up=%b down=%b valid=%b want 0 0 0", bus.Up, bus.Down, bus.Valid);
    end
    bus.IDir = 4'b1000;
    repeat (3) tick();
    checks++;
    if (bus.Up !== 1'b0) begin
      failures++;
      $display("FAIL debounce_early: got up=%b want 0", bus.Up);
    end
    tick();
    bus.IReadable = 1'b0;
    checks++;
    if (bus.Up !== 1'b1 || bus.Valid !== 1'b1) begin
      failures++;
      $display("FAIL debounce_load: got up=%b valid=%b want 1 1", bus.Up, bus.Valid);
    end
    $display("test_debounce: dir=%b valid=%b src=%b", {bus.Up, bus.Down, bus.Left, bus.Right}, bus.Valid, bus.Source);
  endtask
`endif

  initial begin
    test_reset();
`ifdef INPUT_ARB_DEBOUNCE_EN
    test_debounce();
`else
    test_manual_ir();
    test_auto_tie();
    test_hold_release();
    test_sanitize();
    test_choice_change();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
